// File: rtl/rv_decode_stage_pkg.sv
// Shared types and encodings for the RV32/RV64 IM decode stage: opcodes, funct fields,
// micro-op and immediate-type enums, the per-lane decode record and the skid state.
package rv_decode_stage_pkg;

  localparam logic [6:0] OP_LUI      = 7'b0110111;
  localparam logic [6:0] OP_AUIPC    = 7'b0010111;
  localparam logic [6:0] OP_JAL      = 7'b1101111;
  localparam logic [6:0] OP_JALR     = 7'b1100111;
  localparam logic [6:0] OP_BRANCH   = 7'b1100011;
  localparam logic [6:0] OP_LOAD     = 7'b0000011;
  localparam logic [6:0] OP_STORE    = 7'b0100011;
  localparam logic [6:0] OP_IMM      = 7'b0010011;
  localparam logic [6:0] OP_IMM32    = 7'b0011011;
  localparam logic [6:0] OP_OP       = 7'b0110011;
  localparam logic [6:0] OP_OP32     = 7'b0111011;
  localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;
  localparam logic [5:0] F6_SRL    = 6'b000000;
  localparam logic [5:0] F6_SRA    = 6'b010000;

  localparam logic [2:0] F3_JALR     = 3'b000;
  localparam logic [2:0] F3_FENCE    = 3'b000;
  localparam logic [2:0] F3_PRIV     = 3'b000;
  localparam logic [2:0] F3_CSR_RSVD = 3'b100;

  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_SRET   = 32'h1020_0073;
  localparam logic [31:0] INST_MRET   = 32'h3020_0073;

  // UOP_ADDI encodes as 0 so empty and illegal lanes carry the same uop bits.
  typedef enum logic [7:0] {
    UOP_ADDI, UOP_SLTI, UOP_SLTIU, UOP_XORI, UOP_ORI, UOP_ANDI, UOP_SLLI, UOP_SRLI, UOP_SRAI,
    UOP_LUI, UOP_AUIPC, UOP_JAL, UOP_JALR,
    UOP_BEQ, UOP_BNE, UOP_BLT, UOP_BGE, UOP_BLTU, UOP_BGEU,
    UOP_LB, UOP_LH, UOP_LW, UOP_LD, UOP_LBU, UOP_LHU, UOP_LWU,
    UOP_SB, UOP_SH, UOP_SW, UOP_SD,
    UOP_ADD, UOP_SUB, UOP_SLL, UOP_SLT, UOP_SLTU, UOP_XOR, UOP_SRL, UOP_SRA, UOP_OR, UOP_AND,
    UOP_ADDIW, UOP_SLLIW, UOP_SRLIW, UOP_SRAIW,
    UOP_ADDW, UOP_SUBW, UOP_SLLW, UOP_SRLW, UOP_SRAW,
    UOP_MUL, UOP_MULH, UOP_MULHSU, UOP_MULHU, UOP_DIV, UOP_DIVU, UOP_REM, UOP_REMU,
    UOP_MULW, UOP_DIVW, UOP_DIVUW, UOP_REMW, UOP_REMUW,
    UOP_FENCE, UOP_ECALL, UOP_EBREAK, UOP_MRET, UOP_SRET,
    UOP_CSRRW, UOP_CSRRS, UOP_CSRRC, UOP_CSRRWI, UOP_CSRRSI, UOP_CSRRCI
  } uop_t;

  typedef enum logic [3:0] {IMM_R, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_type_t;

  typedef enum logic [1:0] {SKID_EMPTY, SKID_ONE, SKID_TWO} skid_state_t;

  typedef struct packed {
    uop_t        uop;
    imm_type_t   imm_type;
    logic [63:0] imm;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        rd_we;
    logic        illegal;
  } dec_lane_t;

endpackage

// File: rtl/rv_decode_stage_if.sv
// Fetch-side and rename-side bundle signals of the decode stage.
// Handshake: a side transfers on the rising edge where its valid && ready are both 1; valid
// never waits on ready, and a held valid keeps its payload stable until the transfer.
interface rv_decode_stage_if #(
  parameter int XLEN = 64,
  parameter int W    = 2
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [W-1:0]      in_lane_vld;
  logic [W*32-1:0]   in_inst;
  logic [XLEN-1:0]   in_pc;
  logic              out_valid;
  logic              out_ready;
  logic [W-1:0]      out_lane_vld;
  logic [W*8-1:0]    out_uop;
  logic [W*4-1:0]    out_imm_type;
  logic [W*XLEN-1:0] out_imm;
  logic [W*5-1:0]    out_rd;
  logic [W*5-1:0]    out_rs1;
  logic [W*5-1:0]    out_rs2;
  logic [W-1:0]      out_rd_we;
  logic [W-1:0]      out_illegal;
  logic [XLEN-1:0]   out_pc;

  modport master (
    output flush, in_valid, in_lane_vld, in_inst, in_pc, out_ready,
    input  in_ready, out_valid, out_lane_vld, out_uop, out_imm_type, out_imm,
           out_rd, out_rs1, out_rs2, out_rd_we, out_illegal, out_pc
  );

  modport slave (
    input  flush, in_valid, in_lane_vld, in_inst, in_pc, out_ready,
    output in_ready, out_valid, out_lane_vld, out_uop, out_imm_type, out_imm,
           out_rd, out_rs1, out_rs2, out_rd_we, out_illegal, out_pc
  );
endinterface

// File: rtl/rv_decode_lane.sv
// Combinational decoder for one 32-bit RV32/RV64 IM instruction into a dec_lane_t record.
// Any illegal encoding collapses to a zeroed ADDI with the illegal flag set.
module rv_decode_lane
  import rv_decode_stage_pkg::*;
#(
  parameter int XLEN      = 64,
  parameter bit EN_M      = 1'b1,
  parameter bit EN_SYSTEM = 1'b1
) (
  input  logic [31:0] inst,
  output dec_lane_t   dec
);
  localparam bit RV64 = (XLEN == 64);

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [5:0]  f6;
  logic        shamt_ok;
  uop_t        uop;
  imm_type_t   itype;
  logic        ok, has_rd, has_rs1, has_rs2, csr_imm;
  logic [63:0] imm;

  assign opc      = inst[6:0];
  assign f3       = inst[14:12];
  assign f7       = inst[31:25];
  assign f6       = inst[31:26];
  assign shamt_ok = RV64 || !inst[25];

  always_comb begin
    uop = UOP_ADDI; itype = IMM_R; ok = 1'b0;
    has_rd = 1'b0; has_rs1 = 1'b0; has_rs2 = 1'b0; csr_imm = 1'b0;
    case (opc)
      OP_LUI:   begin uop = UOP_LUI;   itype = IMM_U; has_rd = 1'b1; ok = 1'b1; end
      OP_AUIPC: begin uop = UOP_AUIPC; itype = IMM_U; has_rd = 1'b1; ok = 1'b1; end
      OP_JAL:   begin uop = UOP_JAL;   itype = IMM_J; has_rd = 1'b1; ok = 1'b1; end
      OP_JALR:  begin
        uop = UOP_JALR; itype = IMM_I; has_rd = 1'b1; has_rs1 = 1'b1; ok = (f3 == F3_JALR);
      end
      OP_BRANCH: begin
        itype = IMM_B; has_rs1 = 1'b1; has_rs2 = 1'b1; ok = 1'b1;
        case (f3)
          3'd0: uop = UOP_BEQ;
          3'd1: uop = UOP_BNE;
          3'd4: uop = UOP_BLT;
          3'd5: uop = UOP_BGE;
          3'd6: uop = UOP_BLTU;
          3'd7: uop = UOP_BGEU;
          default: ok = 1'b0;
        endcase
      end
      OP_LOAD: begin
        itype = IMM_I; has_rd = 1'b1; has_rs1 = 1'b1; ok = 1'b1;
        case (f3)
          3'd0: uop = UOP_LB;
          3'd1: uop = UOP_LH;
          3'd2: uop = UOP_LW;
          3'd3: begin uop = UOP_LD;  ok = RV64; end
          3'd4: uop = UOP_LBU;
          3'd5: uop = UOP_LHU;
          3'd6: begin uop = UOP_LWU; ok = RV64; end
          default: ok = 1'b0;
        endcase
      end
      OP_STORE: begin
        itype = IMM_S; has_rs1 = 1'b1; has_rs2 = 1'b1; ok = 1'b1;
        case (f3)
          3'd0: uop = UOP_SB;
          3'd1: uop = UOP_SH;
          3'd2: uop = UOP_SW;
          3'd3: begin uop = UOP_SD; ok = RV64; end
          default: ok = 1'b0;
        endcase
      end
      OP_IMM: begin
        itype = IMM_I; has_rd = 1'b1; has_rs1 = 1'b1; ok = 1'b1;
        case (f3)
          3'd0: uop = UOP_ADDI;
          3'd1: begin uop = UOP_SLLI; ok = (f6 == F6_SRL) && shamt_ok; end
          3'd2: uop = UOP_SLTI;
          3'd3: uop = UOP_SLTIU;
          3'd4: uop = UOP_XORI;
          3'd5: begin
            uop = (f6 == F6_SRA) ? UOP_SRAI : UOP_SRLI;
            ok  = ((f6 == F6_SRL) || (f6 == F6_SRA)) && shamt_ok;
          end
          3'd6: uop = UOP_ORI;
          default: uop = UOP_ANDI;
        endcase
      end
      OP_IMM32: begin
        itype = IMM_I; has_rd = 1'b1; has_rs1 = 1'b1;
        case (f3)
          3'd0: begin uop = UOP_ADDIW; ok = RV64; end
          3'd1: begin uop = UOP_SLLIW; ok = RV64 && (f7 == F7_BASE); end
          3'd5: begin
            uop = (f7 == F7_ALT) ? UOP_SRAIW : UOP_SRLIW;
            ok  = RV64 && ((f7 == F7_BASE) || (f7 == F7_ALT));
          end
          default: ok = 1'b0;
        endcase
      end
      OP_OP: begin
        has_rd = 1'b1; has_rs1 = 1'b1; has_rs2 = 1'b1; ok = 1'b1;
        case (f7)
          F7_BASE: begin
            case (f3)
              3'd0: uop = UOP_ADD;
              3'd1: uop = UOP_SLL;
              3'd2: uop = UOP_SLT;
              3'd3: uop = UOP_SLTU;
              3'd4: uop = UOP_XOR;
              3'd5: uop = UOP_SRL;
              3'd6: uop = UOP_OR;
              default: uop = UOP_AND;
            endcase
          end
          F7_ALT: begin
            case (f3)
              3'd0: uop = UOP_SUB;
              3'd5: uop = UOP_SRA;
              default: ok = 1'b0;
            endcase
          end
          F7_MULDIV: begin
            ok = EN_M;
            case (f3)
              3'd0: uop = UOP_MUL;
              3'd1: uop = UOP_MULH;
              3'd2: uop = UOP_MULHSU;
              3'd3: uop = UOP_MULHU;
              3'd4: uop = UOP_DIV;
              3'd5: uop = UOP_DIVU;
              3'd6: uop = UOP_REM;
              default: uop = UOP_REMU;
            endcase
          end
          default: ok = 1'b0;
        endcase
      end
      OP_OP32: begin
        has_rd = 1'b1; has_rs1 = 1'b1; has_rs2 = 1'b1; ok = RV64;
        case ({f7, f3})
          {F7_BASE, 3'd0}:   uop = UOP_ADDW;
          {F7_BASE, 3'd1}:   uop = UOP_SLLW;
          {F7_BASE, 3'd5}:   uop = UOP_SRLW;
          {F7_ALT, 3'd0}:    uop = UOP_SUBW;
          {F7_ALT, 3'd5}:    uop = UOP_SRAW;
          {F7_MULDIV, 3'd0}: begin uop = UOP_MULW;  ok = RV64 && EN_M; end
          {F7_MULDIV, 3'd4}: begin uop = UOP_DIVW;  ok = RV64 && EN_M; end
          {F7_MULDIV, 3'd5}: begin uop = UOP_DIVUW; ok = RV64 && EN_M; end
          {F7_MULDIV, 3'd6}: begin uop = UOP_REMW;  ok = RV64 && EN_M; end
          {F7_MULDIV, 3'd7}: begin uop = UOP_REMUW; ok = RV64 && EN_M; end
          default: ok = 1'b0;
        endcase
      end
      OP_MISC_MEM: begin
        uop = UOP_FENCE; itype = IMM_I; ok = EN_SYSTEM && (f3 == F3_FENCE);
      end
      OP_SYSTEM: begin
        if (f3 == F3_PRIV) begin
          ok = EN_SYSTEM;
          if (inst == INST_ECALL)       uop = UOP_ECALL;
          else if (inst == INST_EBREAK) uop = UOP_EBREAK;
          else if (inst == INST_MRET)   uop = UOP_MRET;
          else if (inst == INST_SRET)   uop = UOP_SRET;
          else                          ok  = 1'b0;
        end else begin
          // CSR*I variants reuse the rs1 field as the 5-bit uimm.
          itype = IMM_I; has_rd = 1'b1; has_rs1 = 1'b1; csr_imm = 1'b1;
          ok = EN_SYSTEM && (f3 != F3_CSR_RSVD);
          case (f3)
            3'd1: uop = UOP_CSRRW;
            3'd2: uop = UOP_CSRRS;
            3'd3: uop = UOP_CSRRC;
            3'd5: uop = UOP_CSRRWI;
            3'd6: uop = UOP_CSRRSI;
            default: uop = UOP_CSRRCI;
          endcase
        end
      end
      default: ok = 1'b0;
    endcase
  end

  always_comb begin
    case (itype)
      IMM_I:   imm = {{52{inst[31]}}, inst[31:20]};
      IMM_S:   imm = {{52{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:   imm = {{51{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U:   imm = {{32{inst[31]}}, inst[31:12], 12'b0};
      IMM_J:   imm = {{43{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm = '0;
    endcase
    if (csr_imm) imm = {52'b0, inst[31:20]};
  end

  always_comb begin
    dec         = '0;
    dec.uop     = UOP_ADDI;
    dec.illegal = 1'b1;
    if (ok && (inst[1:0] == 2'b11)) begin
      dec.uop      = uop;
      dec.imm_type = itype;
      dec.imm      = imm;
      dec.rd       = has_rd  ? inst[11:7]  : 5'd0;
      dec.rs1      = has_rs1 ? inst[19:15] : 5'd0;
      dec.rs2      = has_rs2 ? inst[24:20] : 5'd0;
      dec.rd_we    = has_rd && (inst[11:7] != 5'd0);
      dec.illegal  = 1'b0;
    end
  end

endmodule

// File: rtl/rv_decode_stage.sv
// Multi-lane decode pipeline stage: per-lane combinational decoders feeding a 2-entry skid
// buffer (main + spare) so in_ready comes straight from a flop and throughput is 1 bundle/cycle.
module rv_decode_stage
  import rv_decode_stage_pkg::*;
#(
  parameter int XLEN         = 64,
  parameter int DECODE_WIDTH = 2,
  parameter bit EN_M         = 1'b1,
  parameter bit EN_SYSTEM    = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  rv_decode_stage_if.slave    bus,
  output skid_state_t         dbg_state
);
  localparam int W = DECODE_WIDTH;

  skid_state_t     state, state_nxt;
  logic            in_ready_q, out_valid_q;
  logic            in_fire, out_fire;
  logic            ld_main_in, ld_main_spare, ld_spare, clr_main;
  logic [W-1:0]    main_vld, spare_vld;
  logic [XLEN-1:0] main_pc, spare_pc;
  dec_lane_t       main_dec  [W];
  dec_lane_t       spare_dec [W];
  dec_lane_t       nxt_dec   [W];

  assign in_fire       = bus.in_valid && in_ready_q;
  assign out_fire      = out_valid_q && bus.out_ready;
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign dbg_state     = state;

  // Flush wins over everything, including an input handshake in the same cycle.
  always_comb begin
    state_nxt     = state;
    ld_main_in    = 1'b0;
    ld_main_spare = 1'b0;
    ld_spare      = 1'b0;
    clr_main      = 1'b0;
    if (bus.flush) begin
      state_nxt = SKID_EMPTY;
      clr_main  = 1'b1;
    end else begin
      case (state)
        SKID_EMPTY: if (in_fire) begin state_nxt = SKID_ONE; ld_main_in = 1'b1; end
        SKID_ONE: begin
          if (in_fire && out_fire) ld_main_in = 1'b1;
          else if (in_fire) begin state_nxt = SKID_TWO; ld_spare = 1'b1; end
          else if (out_fire) state_nxt = SKID_EMPTY;
        end
        SKID_TWO: if (out_fire) begin state_nxt = SKID_ONE; ld_main_spare = 1'b1; end
        default: state_nxt = SKID_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= SKID_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      main_vld    <= '0;
      main_pc     <= '0;
      main_dec    <= '{default: '0};
      spare_vld   <= '0;
      spare_pc    <= '0;
      spare_dec   <= '{default: '0};
    end else begin
      state       <= state_nxt;
      in_ready_q  <= (state_nxt != SKID_TWO);
      out_valid_q <= (state_nxt != SKID_EMPTY);
      if (clr_main) begin
        main_vld <= '0;
        main_pc  <= '0;
        main_dec <= '{default: '0};
      end else if (ld_main_in) begin
        main_vld <= bus.in_lane_vld;
        main_pc  <= bus.in_pc;
        main_dec <= nxt_dec;
      end else if (ld_main_spare) begin
        main_vld <= spare_vld;
        main_pc  <= spare_pc;
        main_dec <= spare_dec;
      end
      if (ld_spare) begin
        spare_vld <= bus.in_lane_vld;
        spare_pc  <= bus.in_pc;
        spare_dec <= nxt_dec;
      end
    end
  end

  assign bus.out_lane_vld = main_vld;
  assign bus.out_pc       = main_pc;

  for (genvar i = 0; i < W; i++) begin : g_lane
    dec_lane_t lane_dec;

    rv_decode_lane #(
      .XLEN      (XLEN),
      .EN_M      (EN_M),
      .EN_SYSTEM (EN_SYSTEM)
    ) u_lane (
      .inst (bus.in_inst[i*32 +: 32]),
      .dec  (lane_dec)
    );

    assign nxt_dec[i] = bus.in_lane_vld[i] ? lane_dec : '0;

    assign bus.out_uop[i*8 +: 8]         = main_dec[i].uop;
    assign bus.out_imm_type[i*4 +: 4]    = main_dec[i].imm_type;
    assign bus.out_imm[i*XLEN +: XLEN]   = main_dec[i].imm[XLEN-1:0];
    assign bus.out_rd[i*5 +: 5]          = main_dec[i].rd;
    assign bus.out_rs1[i*5 +: 5]         = main_dec[i].rs1;
    assign bus.out_rs2[i*5 +: 5]         = main_dec[i].rs2;
    assign bus.out_rd_we[i]              = main_dec[i].rd_we;
    assign bus.out_illegal[i]            = main_dec[i].illegal;
  end

endmodule

// File: tb/tb_rv_decode_stage.sv
// Directed bench for rv_decode_stage: an RV64 (M enabled) instance and an RV32 (M disabled)
// instance, covering decode results, skid backpressure, flush and asynchronous reset.
module tb_rv_decode_stage;
  import rv_decode_stage_pkg::*;

  logic        clk;
  logic        rst_n;
  skid_state_t dbg_a, dbg_b;
  int          n_cmp;
  int          n_err;

  rv_decode_stage_if #(.XLEN(64), .W(2)) ia ();
  rv_decode_stage_if #(.XLEN(32), .W(2)) ib ();

  rv_decode_stage #(.XLEN(64), .DECODE_WIDTH(2), .EN_M(1'b1), .EN_SYSTEM(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ia), .dbg_state(dbg_a)
  );

  rv_decode_stage #(.XLEN(32), .DECODE_WIDTH(2), .EN_M(1'b0), .EN_SYSTEM(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ib), .dbg_state(dbg_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic drive_a(input logic v, input logic [1:0] lv, input logic [31:0] i0,
                         input logic [31:0] i1, input logic [63:0] pc);
    ia.in_valid    = v;
    ia.in_lane_vld = lv;
    ia.in_inst     = {i1, i0};
    ia.in_pc       = pc;
  endtask

  task automatic drive_b(input logic v, input logic [1:0] lv, input logic [31:0] i0,
                         input logic [31:0] i1, input logic [31:0] pc);
    ib.in_valid    = v;
    ib.in_lane_vld = lv;
    ib.in_inst     = {i1, i0};
    ib.in_pc       = pc;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    ia.flush = 1'b0; ia.out_ready = 1'b1;
    ib.flush = 1'b0; ib.out_ready = 1'b1;
    drive_a(1'b0, 2'b00, 32'h0, 32'h0, 64'h0);
    drive_b(1'b0, 2'b00, 32'h0, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1;

    // reset state
    check("rst_out_valid", ia.out_valid, 1'b0);
    check("rst_in_ready", ia.in_ready, 1'b1);
    check("rst_out_pc", ia.out_pc, 64'h0);
    check("rst_out_uop", ia.out_uop, 16'h0);
    check("rst_state", dbg_a, SKID_EMPTY);
    check("rst_b_out_valid", ib.out_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // two ADDIs, positive and all-ones immediate
    drive_a(1'b1, 2'b11, 32'h00500093, 32'hFFF00113, 64'h1000);
    tick();
    check("addi_valid", ia.out_valid, 1'b1);
    check("addi_lane_vld", ia.out_lane_vld, 2'b11);
    check("addi_l0_uop", ia.out_uop[7:0], UOP_ADDI);
    check("addi_l0_type", ia.out_imm_type[3:0], IMM_I);
    check("addi_l0_rd", ia.out_rd[4:0], 5'd1);
    check("addi_l0_imm", ia.out_imm[63:0], 64'd5);
    check("addi_l1_rd", ia.out_rd[9:5], 5'd2);
    check("addi_l1_imm", ia.out_imm[127:64], 64'hFFFF_FFFF_FFFF_FFFF);
    check("addi_rd_we", ia.out_rd_we, 2'b11);
    check("addi_illegal", ia.out_illegal, 2'b00);
    check("addi_pc", ia.out_pc, 64'h1000);

    // mul x0,x1,x2 with M enabled; lane 1 masked off (garbage instruction)
    drive_a(1'b1, 2'b01, 32'h02208033, 32'hFFFFFFFF, 64'h1008);
    tick();
    check("mul_uop", ia.out_uop[7:0], UOP_MUL);
    check("mul_type", ia.out_imm_type[3:0], IMM_R);
    check("mul_rd", ia.out_rd[4:0], 5'd0);
    check("mul_rs1", ia.out_rs1[4:0], 5'd1);
    check("mul_rs2", ia.out_rs2[4:0], 5'd2);
    check("mul_rd_we", ia.out_rd_we, 2'b00);
    check("mul_illegal", ia.out_illegal, 2'b00);
    check("mask_lane_vld", ia.out_lane_vld, 2'b01);
    check("mask_l1_uop", ia.out_uop[15:8], 8'h00);
    check("mask_l1_imm", ia.out_imm[127:64], 64'h0);
    check("mask_pc", ia.out_pc, 64'h1008);

    // slli x1,x1,32 is legal on RV64; low bits != 2'b11 is illegal
    drive_a(1'b1, 2'b11, 32'h02009093, 32'h00500090, 64'h1010);
    tick();
    check("slli64_uop", ia.out_uop[7:0], UOP_SLLI);
    check("slli64_imm", ia.out_imm[63:0], 64'h20);
    check("slli64_rs1", ia.out_rs1[4:0], 5'd1);
    check("lowbits_illegal", ia.out_illegal, 2'b10);
    check("lowbits_rd", ia.out_rd[9:5], 5'd0);
    check("lowbits_rd_we", ia.out_rd_we, 2'b01);

    // csrrs x5, 0xF14, x0: csr address zero-extended
    drive_a(1'b1, 2'b01, 32'hF14022F3, 32'h0, 64'h1018);
    tick();
    check("csr_uop", ia.out_uop[7:0], UOP_CSRRS);
    check("csr_imm", ia.out_imm[63:0], 64'hF14);
    check("csr_rd", ia.out_rd[4:0], 5'd5);
    check("csr_rd_we", ia.out_rd_we, 2'b01);
    drive_a(1'b0, 2'b00, 32'h0, 32'h0, 64'h0);
    tick();
    check("drain_valid", ia.out_valid, 1'b0);

    // RV32 without M: mul and ld illegal
    drive_b(1'b1, 2'b11, 32'h02208033, 32'h0000B083, 32'h400);
    tick();
    check("b_illegal", ib.out_illegal, 2'b11);
    check("b_mul_uop", ib.out_uop[7:0], UOP_ADDI);
    check("b_mul_rs1", ib.out_rs1[4:0], 5'd0);
    check("b_rd_we", ib.out_rd_we, 2'b00);
    check("b_ld_imm", ib.out_imm[63:32], 32'h0);

    // RV32: jal x0,0 legal; slli with shamt bit 5 illegal
    drive_b(1'b1, 2'b11, 32'h0000006F, 32'h02009093, 32'h404);
    tick();
    check("b_jal_uop", ib.out_uop[7:0], UOP_JAL);
    check("b_jal_type", ib.out_imm_type[3:0], IMM_J);
    check("b_jal_imm", ib.out_imm[31:0], 32'h0);
    check("b_slli_illegal", ib.out_illegal, 2'b10);
    check("b_pc", ib.out_pc, 32'h404);
    drive_b(1'b0, 2'b00, 32'h0, 32'h0, 32'h0);

    // backpressure: three stalled cycles with input held valid
    ia.out_ready = 1'b0;
    drive_a(1'b1, 2'b01, 32'h00100193, 32'h0, 64'h2000);
    tick();
    check("bp1_valid", ia.out_valid, 1'b1);
    check("bp1_in_ready", ia.in_ready, 1'b1);
    drive_a(1'b1, 2'b01, 32'h00200193, 32'h0, 64'h2008);
    tick();
    check("bp2_in_ready", ia.in_ready, 1'b0);
    check("bp2_state", dbg_a, SKID_TWO);
    check("bp2_pc", ia.out_pc, 64'h2000);
    drive_a(1'b1, 2'b01, 32'h00300193, 32'h0, 64'h2010);
    tick();
    check("bp3_in_ready", ia.in_ready, 1'b0);
    check("bp3_pc_hold", ia.out_pc, 64'h2000);
    check("bp3_imm_hold", ia.out_imm[63:0], 64'd1);
    ia.out_ready = 1'b1;
    tick();
    check("rel1_pc", ia.out_pc, 64'h2008);
    check("rel1_imm", ia.out_imm[63:0], 64'd2);
    check("rel1_in_ready", ia.in_ready, 1'b1);
    tick();
    check("rel2_pc", ia.out_pc, 64'h2010);
    check("rel2_imm", ia.out_imm[63:0], 64'd3);
    drive_a(1'b0, 2'b00, 32'h0, 32'h0, 64'h0);
    tick();
    check("rel3_valid", ia.out_valid, 1'b0);

    // flush with both entries full and input valid
    ia.out_ready = 1'b0;
    drive_a(1'b1, 2'b01, 32'h00100193, 32'h0, 64'h3000);
    tick();
    drive_a(1'b1, 2'b01, 32'h00200193, 32'h0, 64'h3008);
    tick();
    check("fl_full_state", dbg_a, SKID_TWO);
    drive_a(1'b1, 2'b01, 32'h00300193, 32'h0, 64'h3010);
    ia.flush = 1'b1;
    tick();
    check("fl_valid", ia.out_valid, 1'b0);
    check("fl_in_ready", ia.in_ready, 1'b1);
    ia.flush = 1'b0;
    ia.out_ready = 1'b1;
    drive_a(1'b0, 2'b00, 32'h0, 32'h0, 64'h0);
    tick();
    check("fl_no_stale", ia.out_valid, 1'b0);

    // input handshake in the flush cycle is discarded
    drive_a(1'b1, 2'b01, 32'h00400193, 32'h0, 64'h3018);
    ia.flush = 1'b1;
    tick();
    check("fl_in_drop", ia.out_valid, 1'b0);
    ia.flush = 1'b0;
    drive_a(1'b0, 2'b00, 32'h0, 32'h0, 64'h0);
    tick();
    check("fl_in_drop2", ia.out_valid, 1'b0);

    // asynchronous reset while a bundle is held
    ia.out_ready = 1'b0;
    drive_a(1'b1, 2'b01, 32'h00500193, 32'h0, 64'h4000);
    tick();
    check("ar_pre_valid", ia.out_valid, 1'b1);
    drive_a(1'b0, 2'b00, 32'h0, 32'h0, 64'h0);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_valid", ia.out_valid, 1'b0);
    check("ar_in_ready", ia.in_ready, 1'b1);
    check("ar_pc", ia.out_pc, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    ia.out_ready = 1'b1;
    tick();
    check("ar_post_valid", ia.out_valid, 1'b0);
    drive_a(1'b1, 2'b01, 32'h00600193, 32'h0, 64'h4008);
    tick();
    check("ar_new_valid", ia.out_valid, 1'b1);
    check("ar_new_pc", ia.out_pc, 64'h4008);
    check("ar_new_imm", ia.out_imm[63:0], 64'd6);
    drive_a(1'b0, 2'b00, 32'h0, 32'h0, 64'h0);
    tick();
    check("ar_once", ia.out_valid, 1'b0);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
